// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU and LSU results share one register-file write port.
// Fixed LSU priority, with a starvation counter that forces an ALU grant.
module wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [3:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        rf_we,
    output logic [3:0]  rf_rd,
    output logic [31:0] rf_data,
    output logic [15:0] pend_mask,
    output logic [3:0]  starve_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        alu_grant;
    logic        lsu_grant;
    logic        xfer;
    logic [3:0]  win_rd;
    logic [31:0] win_data;
    logic [3:0]  starve_q;

    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (rst_n) begin
            unique case (1'b1)
                alu_valid && lsu_valid: begin
                    if (starve_q >= LIMIT)
                        alu_grant = 1'b1;
                    else
                        lsu_grant = 1'b1;
                end
                alu_valid && !lsu_valid: alu_grant = 1'b1;
                lsu_valid && !alu_valid: lsu_grant = 1'b1;
                default: ;
            endcase
        end
    end

    assign alu_ready = alu_grant;
    assign lsu_ready = lsu_grant;
    assign xfer      = alu_grant || lsu_grant;
    assign win_rd    = alu_grant ? alu_rd : lsu_rd;
    assign win_data  = alu_grant ? alu_data : lsu_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 4'd0;
            rf_we    <= 1'b0;
            rf_rd    <= 4'd0;
            rf_data  <= 32'd0;
        end else begin
            if (alu_grant || !alu_valid)
                starve_q <= 4'd0;
            else if (lsu_grant && starve_q < LIMIT)
                starve_q <= starve_q + 4'd1;

            // x0 results are accepted but never written
            rf_we <= xfer && (win_rd != 4'd0);
            if (xfer && win_rd != 4'd0) begin
                rf_rd   <= win_rd;
                rf_data <= win_data;
            end
        end
    end

    assign starve_cnt = starve_q;
    assign pend_mask  = rf_we ? (16'd1 << rf_rd) : 16'd0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized
// handshake run against a rule-level grant/writeback model.
module tb_wb_arbiter;

    localparam int LIMIT = 3;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [3:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [3:0]  rf_rd;
    logic [31:0] rf_data;
    logic [15:0] pend_mask;
    logic [3:0]  starve_cnt;

    int vectors = 0;
    int miscompares = 0;

    wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .lsu_valid(lsu_valid),
        .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd),
        .lsu_data(lsu_data),
        .rf_we(rf_we),
        .rf_rd(rf_rd),
        .rf_data(rf_data),
        .pend_mask(pend_mask),
        .starve_cnt(starve_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = 4'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 4'd0; lsu_data = 32'd0;
        repeat (2) step();
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_rd = 4'd9;  alu_data = 32'h9999;
        lsu_valid = 1'b1; lsu_rd = 4'd10; lsu_data = 32'hAAAA;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({alu_ready, lsu_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready got %b exp 00", {alu_ready, lsu_ready});
        end
        vectors++;
        if (rf_we !== 1'b0 || pend_mask !== 16'h0 || starve_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state got we=%b pend=%h cnt=%0d exp 0/0/0",
                     rf_we, pend_mask, starve_cnt);
        end
        vectors++;
        if (rf_rd !== 4'd0 || rf_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_rf got rd=%0d data=%h exp 0/0", rf_rd, rf_data);
        end
        step();
        lsu_valid = 1'b0;
        alu_rd = 4'd5; alu_data = 32'hDEAD_BEEF;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({alu_ready, lsu_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL release_grant got %b exp 10", {alu_ready, lsu_ready});
        end
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b1 || rf_rd !== 4'd5 || rf_data !== 32'hDEAD_BEEF ||
            pend_mask !== 16'h0020) begin
            miscompares++;
            $display("FAIL release_write got we=%b rd=%0d data=%h pend=%h exp 1/5/deadbeef/0020",
                     rf_we, rf_rd, rf_data, pend_mask);
        end
        step();
    endtask

    task automatic test_single_stream();
        for (int i = 1; i <= 4; i++) begin
            lsu_valid = 1'b1;
            lsu_rd = 4'(i);
            lsu_data = 32'(i * 'h11);
            @(negedge clk);
            vectors++;
            if (lsu_ready !== 1'b1 || alu_ready !== 1'b0 || starve_cnt !== 4'd0) begin
                miscompares++;
                $display("FAIL stream_ready[%0d] got l=%b a=%b cnt=%0d exp 1/0/0",
                         i, lsu_ready, alu_ready, starve_cnt);
            end
            if (i > 1) begin
                vectors++;
                if (rf_we !== 1'b1 || rf_rd !== 4'(i - 1) ||
                    rf_data !== 32'((i - 1) * 'h11)) begin
                    miscompares++;
                    $display("FAIL stream_write[%0d] got we=%b rd=%0d data=%h exp rd=%0d",
                             i - 1, rf_we, rf_rd, rf_data, i - 1);
                end
            end
            step();
        end
        lsu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b1 || rf_rd !== 4'd4 || rf_data !== 32'h44) begin
            miscompares++;
            $display("FAIL stream_write[4] got we=%b rd=%0d data=%h exp 1/4/44",
                     rf_we, rf_rd, rf_data);
        end
        step();
    endtask

    task automatic test_starvation();
        logic [3:0]  prev_rd;
        logic [31:0] prev_data;
        logic        exp_a;
        prev_rd = 4'd0;
        prev_data = 32'd0;
        alu_valid = 1'b1; alu_rd = 4'd8; alu_data = 32'hA000_0000;
        lsu_valid = 1'b1; lsu_rd = 4'd1; lsu_data = 32'hB000_0000;
        for (int k = 0; k < 8; k++) begin
            exp_a = (k % (LIMIT + 1)) == LIMIT;
            @(negedge clk);
            vectors++;
            if (alu_ready !== exp_a || lsu_ready !== !exp_a ||
                starve_cnt !== 4'(k % (LIMIT + 1))) begin
                miscompares++;
                $display("FAIL starve[%0d] got a=%b l=%b cnt=%0d exp a=%b cnt=%0d",
                         k, alu_ready, lsu_ready, starve_cnt, exp_a, k % (LIMIT + 1));
            end
            if (k > 0) begin
                vectors++;
                if (rf_we !== 1'b1 || rf_rd !== prev_rd || rf_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL starve_write[%0d] got rd=%0d data=%h exp rd=%0d data=%h",
                             k, rf_rd, rf_data, prev_rd, prev_data);
                end
            end
            prev_rd = exp_a ? alu_rd : lsu_rd;
            prev_data = exp_a ? alu_data : lsu_data;
            step();
            if (exp_a) begin
                alu_rd = alu_rd + 4'd1;
                alu_data = alu_data + 32'd1;
            end else begin
                lsu_rd = lsu_rd + 4'd1;
                lsu_data = lsu_data + 32'd1;
            end
        end
        alu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (lsu_ready !== 1'b1 || rf_rd !== prev_rd || rf_data !== prev_data) begin
            miscompares++;
            $display("FAIL starve_drain got l=%b rd=%0d data=%h exp 1/%0d/%h",
                     lsu_ready, rf_rd, rf_data, prev_rd, prev_data);
        end
        step();
        lsu_valid = 1'b0;
        step();
    endtask

    task automatic test_x0_discard();
        alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 32'hFFFF_FFFF;
        lsu_valid = 1'b1; lsu_rd = 4'd3; lsu_data = 32'h3333;
        step();
        lsu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (alu_ready !== 1'b1 || starve_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL x0_grant got a=%b cnt=%0d exp 1/1", alu_ready, starve_cnt);
        end
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b0 || pend_mask !== 16'h0 || starve_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL x0_discard got we=%b pend=%h cnt=%0d exp 0/0/0",
                     rf_we, pend_mask, starve_cnt);
        end
        step();
    endtask

    task automatic test_collision();
        lsu_valid = 1'b1; lsu_rd = 4'd7; lsu_data = 32'h1;
        step();
        lsu_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 32'h2;
        @(negedge clk);
        vectors++;
        if (alu_ready !== 1'b1 || rf_we !== 1'b1 || rf_data !== 32'h1 ||
            pend_mask !== 16'h0080) begin
            miscompares++;
            $display("FAIL collide_first got a=%b we=%b data=%h pend=%h exp 1/1/1/0080",
                     alu_ready, rf_we, rf_data, pend_mask);
        end
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (rf_we !== 1'b1 || rf_data !== 32'h2 || pend_mask !== 16'h0080) begin
            miscompares++;
            $display("FAIL collide_second got we=%b data=%h pend=%h exp 1/2/0080",
                     rf_we, rf_data, pend_mask);
        end
        step();
    endtask

    task automatic test_random();
        int          streak;
        int          alu_wait;
        bit          have_exp;
        bit          ga;
        bit          gl;
        bit          exp_we;
        logic [3:0]  exp_rd;
        logic [31:0] exp_data;
        bit          a_took;
        bit          l_took;
        int          alu_sent;
        int          lsu_sent;
        int          writes;
        int          exp_writes;
        streak = 0;
        alu_wait = 0;
        have_exp = 1'b0;
        exp_we = 1'b0;
        exp_rd = 4'd0;
        exp_data = 32'd0;
        alu_sent = 0;
        lsu_sent = 0;
        writes = 0;
        exp_writes = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            ga = alu_valid && (!lsu_valid || streak == LIMIT);
            gl = lsu_valid && !ga;
            vectors++;
            if (alu_ready !== ga || lsu_ready !== gl) begin
                miscompares++;
                $display("FAIL rand_grant[%0d] got a=%b l=%b exp a=%b l=%b",
                         c, alu_ready, lsu_ready, ga, gl);
            end
            vectors++;
            if ((alu_ready && lsu_ready) || (alu_ready && !alu_valid) ||
                (lsu_ready && !lsu_valid)) begin
                miscompares++;
                $display("FAIL rand_ready_rule[%0d] got a=%b l=%b va=%b vl=%b",
                         c, alu_ready, lsu_ready, alu_valid, lsu_valid);
            end
            vectors++;
            if (starve_cnt !== 4'(streak)) begin
                miscompares++;
                $display("FAIL rand_starve[%0d] got %0d exp %0d", c, starve_cnt, streak);
            end
            if (have_exp) begin
                vectors++;
                if (rf_we !== exp_we || (exp_we && (rf_rd !== exp_rd || rf_data !== exp_data)) ||
                    pend_mask !== (exp_we ? (16'd1 << exp_rd) : 16'd0)) begin
                    miscompares++;
                    $display("FAIL rand_write[%0d] got we=%b rd=%0d data=%h pend=%h exp we=%b rd=%0d data=%h",
                             c, rf_we, rf_rd, rf_data, pend_mask, exp_we, exp_rd, exp_data);
                end
            end
            if (rf_we === 1'b1) writes++;
            if (alu_valid) alu_wait++;
            if (alu_ready === 1'b1) begin
                vectors++;
                if (alu_wait > LIMIT + 1) begin
                    miscompares++;
                    $display("FAIL rand_alu_wait[%0d] got %0d exp <= %0d",
                             c, alu_wait, LIMIT + 1);
                end
                alu_wait = 0;
            end
            exp_we = (ga || gl) && ((ga ? alu_rd : lsu_rd) != 4'd0);
            if (exp_we) begin
                exp_rd = ga ? alu_rd : lsu_rd;
                exp_data = ga ? alu_data : lsu_data;
                exp_writes++;
            end
            have_exp = 1'b1;
            if (ga || !alu_valid) streak = 0;
            else if (gl) streak = streak + 1;
            a_took = alu_valid && alu_ready;
            l_took = lsu_valid && lsu_ready;
            if (a_took) alu_sent++;
            if (l_took) lsu_sent++;
            step();
            if (!alu_valid || a_took) begin
                alu_valid = $urandom_range(0, 99) < 65;
                alu_rd = 4'($urandom);
                alu_data = $urandom;
            end
            if (!lsu_valid || l_took) begin
                lsu_valid = $urandom_range(0, 99) < 65;
                lsu_rd = 4'($urandom);
                lsu_data = $urandom;
            end
        end
        @(negedge clk);
        if (rf_we === 1'b1) writes++;
        vectors++;
        if (writes != exp_writes) begin
            miscompares++;
            $display("FAIL rand_write_count got %0d exp %0d (alu %0d lsu %0d sent)",
                     writes, exp_writes, alu_sent, lsu_sent);
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_starvation();
        test_x0_discard();
        test_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
